// File: rtl/gate_test_pkg.sv
// Shared types and constants for the exhaustive two-gate tester.
// Holds the FSM state encoding and the golden AND-OR response model.
package gate_test_pkg;

    localparam int unsigned VEC_W   = 10;
    localparam int unsigned NUM_VEC = 1024;
    localparam logic [VEC_W-1:0] VEC_MAX = VEC_W'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_e;

    // Bit 0 is the p1y response, bit 1 the p2y response.
    function automatic logic [1:0] golden(input logic [VEC_W-1:0] v);
        logic e1;
        logic e2;
        e1 = (v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5]);
        e2 = (v[6] & v[7]) | (v[8] & v[9]);
        return {e2, e1};
    endfunction

endpackage

// File: rtl/gate_tester.sv
// Walks all 1024 input vectors through an external AND-OR device,
// counting mismatches and recording the lowest failing vector.
module gate_tester
    import gate_test_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        p1a,
    output logic        p1b,
    output logic        p1c,
    output logic        p1d,
    output logic        p1e,
    output logic        p1f,
    output logic        p2a,
    output logic        p2b,
    output logic        p2c,
    output logic        p2d,
    input  logic        dut_p1y,
    input  logic        dut_p2y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_count,
    output logic [9:0]  first_fail
);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [VEC_W-1:0] stim_q, stim_d;
    logic [VEC_W-1:0] ff_q, ff_d;
    logic [10:0]      err_q, err_d;
    logic [3:0]       wait_q, wait_d;
    logic [1:0]       gold;
    logic             mism;

    assign gold = golden(vec_q);
    assign mism = (dut_p1y != gold[0]) | (dut_p2y != gold[1]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        stim_d  = stim_q;
        ff_d    = ff_q;
        err_d   = err_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                end
            end
            S_DRIVE: begin
                stim_d  = vec_q;
                wait_d  = 4'(SETTLE - 1);
                state_d = (SETTLE > 1) ? S_WAIT : S_SAMPLE;
            end
            S_WAIT: begin
                if (wait_q <= 4'd1) begin
                    state_d = S_SAMPLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                if (mism) begin
                    // Saturate rather than wrap; only the first miss sets ff.
                    if (err_q != 11'(NUM_VEC)) err_d = err_q + 11'd1;
                    if (err_q == '0) ff_d = vec_q;
                end
                if (vec_q == VEC_MAX) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            stim_q  <= '0;
            ff_q    <= '0;
            err_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            stim_q  <= stim_d;
            ff_q    <= ff_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign {p2d, p2c, p2b, p2a, p1f, p1e, p1d, p1c, p1b, p1a} = stim_q;

    assign busy       = (state_q == S_DRIVE) | (state_q == S_WAIT) |
                        (state_q == S_SAMPLE);
    assign done       = (state_q == S_DONE);
    assign pass       = done & (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_tester.sv
// Scoreboard bench: runs push expected results, monitors pop them on done.
// Covers good/faulty devices, SETTLE=1 and 3, mid-run reset and restarts.
module tb_gate_tester;

    typedef struct {
        int pass;
        int err;
        int ff;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- instance with SETTLE=1 ----------------
    logic        rstn1 = 1'b0, start1 = 1'b0;
    logic        a1, b1, c1, d1, e1, f1, g1, h1, i1, j1;
    logic        y1_1, y2_1, busy1, done1, pass1;
    logic [10:0] err1;
    logic [9:0]  ff1, stim1;
    int          mode1 = 0;

    assign stim1 = {j1, i1, h1, g1, f1, e1, d1, c1, b1, a1};
    assign y1_1  = (mode1 == 1) ? 1'b0 : ((a1 & b1 & c1) | (d1 & e1 & f1));
    assign y2_1  = (mode1 == 2) ? 1'b1 : ((g1 & h1) | (i1 & j1));

    gate_tester #(.SETTLE(1)) u1 (
        .clk(clk), .resetn(rstn1), .start(start1),
        .p1a(a1), .p1b(b1), .p1c(c1), .p1d(d1), .p1e(e1), .p1f(f1),
        .p2a(g1), .p2b(h1), .p2c(i1), .p2d(j1),
        .dut_p1y(y1_1), .dut_p2y(y2_1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1)
    );

    // ---------------- instance with SETTLE=3 ----------------
    logic        rstn3 = 1'b0, start3 = 1'b0;
    logic        a3, b3, c3, d3, e3, f3, g3, h3, i3, j3;
    logic        y1_3, y2_3, busy3, done3, pass3;
    logic [10:0] err3;
    logic [9:0]  ff3;

    assign y1_3 = (a3 & b3 & c3) | (d3 & e3 & f3);
    assign y2_3 = (g3 & h3) | (i3 & j3);

    gate_tester #(.SETTLE(3)) u3 (
        .clk(clk), .resetn(rstn3), .start(start3),
        .p1a(a3), .p1b(b3), .p1c(c3), .p1d(d3), .p1e(e3), .p1f(f3),
        .p2a(g3), .p2b(h3), .p2c(i3), .p2d(j3),
        .dut_p1y(y1_3), .dut_p2y(y2_3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail(ff3)
    );

    exp_t q1[$];
    exp_t q3[$];

    // Monitors: count busy cycles, compare against scoreboard on done rise.
    int   cnt1 = 0, cnt3 = 0;
    logic dd1 = 1'b0, dd3 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rstn1) begin
            cnt1 = 0;
        end else begin
            if (busy1) cnt1++;
            if (done1 && !dd1) begin
                if (q1.size() == 0) begin
                    chk("u1_unexpected_done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("u1_pass", int'(pass1), e.pass);
                    chk("u1_err_count", int'(err1), e.err);
                    chk("u1_first_fail", int'(ff1), e.ff);
                    chk("u1_run_cycles", cnt1, e.cyc);
                end
                cnt1 = 0;
            end
        end
        dd1 = done1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rstn3) begin
            cnt3 = 0;
        end else begin
            if (busy3) cnt3++;
            if (done3 && !dd3) begin
                if (q3.size() == 0) begin
                    chk("u3_unexpected_done", 1, 0);
                end else begin
                    e = q3.pop_front();
                    chk("u3_pass", int'(pass3), e.pass);
                    chk("u3_err_count", int'(err3), e.err);
                    chk("u3_first_fail", int'(ff3), e.ff);
                    chk("u3_run_cycles", cnt3, e.cyc);
                end
                cnt3 = 0;
            end
        end
        dd3 = done3;
    end

    task automatic pulse1();
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
    endtask

    task automatic wait_done1(input string nm);
        int k;
        k = 0;
        while (!done1 && k < 6000) begin
            @(negedge clk); k++;
        end
        if (!done1) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
    endtask

    task automatic run1(input int mode, input int p, input int er,
                        input int ff, input string nm);
        exp_t e;
        mode1 = mode;
        e.pass = p; e.err = er; e.ff = ff; e.cyc = 2048;
        q1.push_back(e);
        pulse1();
        wait_done1(nm);
        chk({nm, "_stim_hold"}, int'(stim1), 1023);
    endtask

    initial begin
        exp_t e;
        int   k;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_pass", int'(pass1), 0);
        chk("rst_err", int'(err1), 0);
        chk("rst_ff", int'(ff1), 0);
        chk("rst_stim", int'(stim1), 0);
        rstn1 = 1'b1;
        rstn3 = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", int'(busy1), 0);

        run1(0, 1, 0, 0, "good");
        run1(1, 0, 240, 7, "p1y_sa0");
        run1(2, 0, 576, 0, "p2y_sa1");

        // Restart from DONE: done drops, counters clear, same results.
        e.pass = 0; e.err = 576; e.ff = 0; e.cyc = 2048;
        q1.push_back(e);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("restart_done_low", int'(done1), 0);
        chk("restart_busy", int'(busy1), 1);
        chk("restart_err_clr", int'(err1), 0);
        wait_done1("rerun");

        // Abort at vector 500 with reset, then require a fresh start.
        mode1 = 0;
        pulse1();
        k = 0;
        while (stim1 != 10'd500 && k < 3000) begin
            @(negedge clk); k++;
        end
        chk("reach_vec500", int'(stim1), 500);
        rstn1 = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy1), 0);
        chk("abort_done", int'(done1), 0);
        chk("abort_pass", int'(pass1), 0);
        chk("abort_err", int'(err1), 0);
        chk("abort_ff", int'(ff1), 0);
        chk("abort_stim", int'(stim1), 0);
        rstn1 = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_stays_idle", int'(busy1), 0);
        run1(1, 0, 240, 7, "post_abort");

        // SETTLE=3 run with ignored start pulses mid-run.
        e.pass = 1; e.err = 0; e.ff = 0; e.cyc = 4096;
        q3.push_back(e);
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        repeat (100) @(negedge clk);
        start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        repeat (1500) @(negedge clk);
        start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        k = 0;
        while (!done3 && k < 6000) begin
            @(negedge clk); k++;
        end
        if (!done3) chk("u3_timeout", 0, 1);
        repeat (2) @(negedge clk);

        chk("q1_drained", q1.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 Parameter SETTLE, default 1, SHALL set the cycles held between applying a vector and sampling the DUT; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 start  input  1  SHALL be a one-cycle request to begin a full test run.
REQ-005 p1a,p1b,p1c,p1d,p1e,p1f,p2a,p2b,p2c,p2d  output  1 each  SHALL be registered stimulus driven to the device under test.
REQ-006 dut_p1y, dut_p2y  input  1 each  SHALL be the device's responses, combinational from the stimulus.
REQ-007 busy  output  1  SHALL be high while a run is in progress.
REQ-008 done  output  1  SHALL be high after a run completes, until the next accepted start or reset.
REQ-009 pass  output  1  SHALL be valid when done=1: high iff err_count==0.
REQ-010 err_count  output  11  SHALL hold the number of vectors with at least one output mismatch.
REQ-011 first_fail  output  10  SHALL hold the lowest failing vector index; 0 if none.

Function
REQ-012 The block SHALL apply vec[9:0] with bit map 0=p1a, 1=p1b, 2=p1c, 3=p1d, 4=p1e, 5=p1f, 6=p2a, 7=p2b, 8=p2c, 9=p2d.
REQ-013 Golden responses SHALL be: exp1=(p1a&p1b&p1c)|(p1d&p1e&p1f); exp2=(p2a&p2b)|(p2c&p2d).
REQ-014 The FSM SHALL have states IDLE, DRIVE, WAIT, SAMPLE, DONE.
REQ-015 IDLE or DONE with start=1 SHALL go to DRIVE, setting vec=0, err_count=0, first_fail=0, done=0.
REQ-016 DRIVE SHALL register vec onto the stimulus outputs, then go to WAIT.
REQ-017 WAIT SHALL hold for SETTLE-1 cycles (0 when SETTLE=1), then go to SAMPLE.
REQ-018 SAMPLE SHALL compare dut_p1y/dut_p2y with the golden responses for vec.
REQ-019 On a mismatch, SAMPLE SHALL increment err_count and, if it is the first mismatch, load first_fail=vec.
REQ-020 From SAMPLE the FSM SHALL go to DRIVE with vec+1, or to DONE if vec==1023.
REQ-021 A run SHALL take exactly 1024*(SETTLE+1) cycles from DRIVE entry to DONE entry.
REQ-022 busy SHALL be high in DRIVE, WAIT and SAMPLE only.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 err_count SHALL saturate at 1024; wrap-around is not permitted.
REQ-025 Stimulus outputs SHALL hold their last vector in DONE.
REQ-026 vec SHALL NOT wrap to 0 within a run.

Reset
REQ-027 With resetn=0 at a clock edge, the block SHALL enter IDLE and clear all outputs and vec to 0 (busy=0, done=0, pass=0), including mid-run.
REQ-028 After reset, the block SHALL require a new start; an aborted run SHALL leave no residue.

Structure
REQ-029 Shared package gate_test_pkg SHALL hold the state enum, VEC_W=10, NUM_VEC=1024, and the golden-response function.
REQ-030 No sub-module SHALL be used; counter, FSM and checker SHALL reside in gate_tester.

Verification
REQ-031 Correct AND-OR DUT model, SETTLE=1, start pulse: done at cycle 2048 after DRIVE entry; pass=1, err_count=0, first_fail=0.
REQ-032 DUT with p1y stuck at 0: err_count=240, first_fail=0x007, pass=0.
REQ-033 DUT with p2y stuck at 1: err_count=576, first_fail=0x000, pass=0.
REQ-034 SETTLE=3, correct DUT: run length is 4096 cycles, pass=1; start pulses mid-run have no effect.
REQ-035 resetn=0 at vector 500, then release: IDLE, all outputs 0. A fresh start gives a full 1024-vector run with correct counts.
REQ-036 start asserted in DONE: done drops next cycle, counters clear, and a second run reproduces identical results.
